// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the register rename file: default widths and the alias
// encoding that means "value is architecturally ready".
package reg_rename_file_pkg;
  localparam int RRF_XLEN     = 32;
  localparam int RRF_NREG     = 32;
  localparam int RRF_ROB_W    = 4;
  localparam int RRF_RD_PORTS = 4;
  localparam int RRF_CM_PORTS = 2;
  localparam int RRF_N_CKPT   = 4;

  localparam logic [RRF_ROB_W-1:0] ALIAS_READY = '0;
endpackage

// File: rtl/reg_rename_file_if.sv
// Bus between the rename/ROB pipeline and the register rename file.
interface reg_rename_file_if
  import reg_rename_file_pkg::*;
#(
  parameter int XLEN     = RRF_XLEN,
  parameter int NREG     = RRF_NREG,
  parameter int ROB_W    = RRF_ROB_W,
  parameter int RD_PORTS = RRF_RD_PORTS,
  parameter int CM_PORTS = RRF_CM_PORTS,
  parameter int N_CKPT   = RRF_N_CKPT
) ();
  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(N_CKPT);

  // Handshake: rdy is a global enable. Every request (ren_valid, cm_valid[c],
  // ckpt_alloc, ckpt_release, restore, flush) is a one-cycle strobe taken at the
  // posedge only when rdy=1; there is no back-pressure. Read outputs are
  // combinational and valid in the same cycle as rd_reg.
  logic                               rdy;
  logic [RD_PORTS-1:0][RW-1:0]        rd_reg;
  logic [RD_PORTS-1:0][XLEN-1:0]      rd_val;
  logic [RD_PORTS-1:0][ROB_W-1:0]     rd_q;
  logic                               ren_valid;
  logic [RW-1:0]                      ren_reg;
  logic [ROB_W-1:0]                   ren_alias;
  logic [CM_PORTS-1:0]                cm_valid;
  logic [CM_PORTS-1:0][RW-1:0]        cm_reg;
  logic [CM_PORTS-1:0][ROB_W-1:0]     cm_alias;
  logic [CM_PORTS-1:0][XLEN-1:0]      cm_data;
  logic                               ckpt_alloc;
  logic [CW-1:0]                      ckpt_free_id;
  logic                               ckpt_full;
  logic                               ckpt_release;
  logic [CW-1:0]                      ckpt_rel_id;
  logic                               restore;
  logic [CW-1:0]                      restore_id;
  logic                               flush;

  modport master (
    output rdy, rd_reg, ren_valid, ren_reg, ren_alias,
           cm_valid, cm_reg, cm_alias, cm_data,
           ckpt_alloc, ckpt_release, ckpt_rel_id, restore, restore_id, flush,
    input  rd_val, rd_q, ckpt_free_id, ckpt_full
  );

  modport slave (
    input  rdy, rd_reg, ren_valid, ren_reg, ren_alias,
           cm_valid, cm_reg, cm_alias, cm_data,
           ckpt_alloc, ckpt_release, ckpt_rel_id, restore, restore_id, flush,
    output rd_val, rd_q, ckpt_free_id, ckpt_full
  );
endinterface

// File: rtl/reg_ckpt_bank.sv
// Alias-table checkpoints: snapshot slots, valid bits, allocation-age matrix and
// the commit-clear logic that keeps saved aliases coherent with retirement.
module reg_ckpt_bank
  import reg_rename_file_pkg::*;
#(
  parameter int NREG     = RRF_NREG,
  parameter int ROB_W    = RRF_ROB_W,
  parameter int CM_PORTS = RRF_CM_PORTS,
  parameter int N_CKPT   = RRF_N_CKPT,
  localparam int RW = $clog2(NREG),
  localparam int CW = $clog2(N_CKPT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy_i,
  input  logic                           flush_i,
  input  logic                           restore_i,
  input  logic [CW-1:0]                  restore_id_i,
  input  logic                           alloc_i,
  input  logic                           release_i,
  input  logic [CW-1:0]                  rel_id_i,
  input  logic [CM_PORTS-1:0]            cm_valid_i,
  input  logic [CM_PORTS-1:0][RW-1:0]    cm_reg_i,
  input  logic [CM_PORTS-1:0][ROB_W-1:0] cm_alias_i,
  input  logic [ROB_W-1:0]               live_i [NREG],
  output logic [ROB_W-1:0]               restore_tbl_o [NREG],
  output logic [CW-1:0]                  free_id_o,
  output logic                           full_o
);
  logic [ROB_W-1:0]  slot_q  [N_CKPT][NREG];
  logic [ROB_W-1:0]  slot_cl [N_CKPT][NREG];
  logic [ROB_W-1:0]  slot_d  [N_CKPT][NREG];
  logic [N_CKPT-1:0] valid_q, valid_d;
  // older_q[i][j] = slot i was allocated before slot j
  logic [N_CKPT-1:0] older_q [N_CKPT];
  logic [N_CKPT-1:0] older_d [N_CKPT];

  always_comb begin
    slot_cl = slot_q;
    for (int i = 0; i < N_CKPT; i++)
      for (int c = 0; c < CM_PORTS; c++)
        if (cm_valid_i[c] && cm_reg_i[c] != '0 && slot_q[i][cm_reg_i[c]] == cm_alias_i[c])
          slot_cl[i][cm_reg_i[c]] = ALIAS_READY;
    restore_tbl_o = slot_cl[restore_id_i];
  end

  always_comb begin
    full_o    = &valid_q;
    free_id_o = '0;
    for (int i = N_CKPT - 1; i >= 0; i--)
      if (!valid_q[i]) free_id_o = i[CW-1:0];
  end

  always_comb begin
    slot_d  = slot_cl;
    valid_d = valid_q;
    older_d = older_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (restore_i) begin
      // The restored slot and everything allocated after it become free.
      for (int j = 0; j < N_CKPT; j++)
        if (j == int'(restore_id_i) || older_q[restore_id_i][j]) valid_d[j] = 1'b0;
    end else begin
      if (release_i) valid_d[rel_id_i] = 1'b0;
      if (alloc_i && !full_o) begin
        slot_d[free_id_o]  = live_i;
        valid_d[free_id_o] = 1'b1;
        for (int i = 0; i < N_CKPT; i++) older_d[i][free_id_o] = valid_q[i];
        older_d[free_id_o] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < N_CKPT; i++) begin
        older_q[i] <= '0;
        for (int r = 0; r < NREG; r++) slot_q[i][r] <= ALIAS_READY;
      end
    end else if (rdy_i) begin
      valid_q <= valid_d;
      older_q <= older_d;
      slot_q  <= slot_d;
    end
  end
endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register producer aliases, commit
// bypass on reads, and checkpoint/restore of the alias table for mispredicts.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int XLEN     = RRF_XLEN,
  parameter int NREG     = RRF_NREG,
  parameter int ROB_W    = RRF_ROB_W,
  parameter int RD_PORTS = RRF_RD_PORTS,
  parameter int CM_PORTS = RRF_CM_PORTS,
  parameter int N_CKPT   = RRF_N_CKPT
) (
  input  logic            clk,
  input  logic            rst,
  reg_rename_file_if.slave rf_if
);
  logic [XLEN-1:0]  reg_q [NREG];
  logic [XLEN-1:0]  reg_d [NREG];
  logic [ROB_W-1:0] alias_q [NREG];
  logic [ROB_W-1:0] alias_d [NREG];
  logic [ROB_W-1:0] alias_cl [NREG];
  logic [ROB_W-1:0] restore_tbl [NREG];

  // Live table after this cycle's commit clears; also the snapshot source.
  always_comb begin
    alias_cl = alias_q;
    for (int c = 0; c < CM_PORTS; c++)
      if (rf_if.cm_valid[c] && rf_if.cm_reg[c] != '0 &&
          alias_q[rf_if.cm_reg[c]] == rf_if.cm_alias[c])
        alias_cl[rf_if.cm_reg[c]] = ALIAS_READY;
  end

  always_comb begin
    reg_d = reg_q;
    for (int c = 0; c < CM_PORTS; c++)
      if (rf_if.cm_valid[c] && rf_if.cm_reg[c] != '0) reg_d[rf_if.cm_reg[c]] = rf_if.cm_data[c];
    alias_d = alias_cl;
    if (rf_if.flush) begin
      for (int r = 0; r < NREG; r++) alias_d[r] = ALIAS_READY;
    end else if (rf_if.restore) begin
      alias_d = restore_tbl;
    end else if (rf_if.ren_valid && rf_if.ren_reg != '0) begin
      alias_d[rf_if.ren_reg] = rf_if.ren_alias;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r]   <= '0;
        alias_q[r] <= ALIAS_READY;
      end
    end else if (rf_if.rdy) begin
      reg_q   <= reg_d;
      alias_q <= alias_d;
    end
  end

  // Youngest commit port whose (reg, alias) matches the live producer forwards.
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rf_if.rd_val[p] = reg_q[rf_if.rd_reg[p]];
      rf_if.rd_q[p]   = alias_q[rf_if.rd_reg[p]];
      for (int c = 0; c < CM_PORTS; c++)
        if (rf_if.cm_valid[c] && rf_if.cm_reg[c] == rf_if.rd_reg[p] &&
            rf_if.cm_alias[c] == alias_q[rf_if.rd_reg[p]]) begin
          rf_if.rd_val[p] = rf_if.cm_data[c];
          rf_if.rd_q[p]   = ALIAS_READY;
        end
      if (rf_if.rd_reg[p] == '0) begin
        rf_if.rd_val[p] = '0;
        rf_if.rd_q[p]   = ALIAS_READY;
      end
    end
  end

  reg_ckpt_bank #(
    .NREG(NREG), .ROB_W(ROB_W), .CM_PORTS(CM_PORTS), .N_CKPT(N_CKPT)
  ) u_ckpt (
    .clk          (clk),
    .rst          (rst),
    .rdy_i        (rf_if.rdy),
    .flush_i      (rf_if.flush),
    .restore_i    (rf_if.restore),
    .restore_id_i (rf_if.restore_id),
    .alloc_i      (rf_if.ckpt_alloc),
    .release_i    (rf_if.ckpt_release),
    .rel_id_i     (rf_if.ckpt_rel_id),
    .cm_valid_i   (rf_if.cm_valid),
    .cm_reg_i     (rf_if.cm_reg),
    .cm_alias_i   (rf_if.cm_alias),
    .live_i       (alias_cl),
    .restore_tbl_o(restore_tbl),
    .free_id_o    (rf_if.ckpt_free_id),
    .full_o       (rf_if.ckpt_full)
  );
endmodule

// File: tb/tb_reg_rename_file.sv
// Randomized and directed bench for reg_rename_file against an array/queue model
// of the alias table, register values and checkpoint allocation order.
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;
  localparam int XLEN = 32, NREG = 32, ROB_W = 4, RD_PORTS = 4, CM_PORTS = 2, N_CKPT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_rename_file_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .RD_PORTS(RD_PORTS),
                       .CM_PORTS(CM_PORTS), .N_CKPT(N_CKPT)) rf_if ();

  reg_rename_file #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .RD_PORTS(RD_PORTS),
                    .CM_PORTS(CM_PORTS), .N_CKPT(N_CKPT)) dut (
    .clk  (clk),
    .rst  (rst),
    .rf_if(rf_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [XLEN-1:0]  m_reg   [NREG];
  logic [ROB_W-1:0] m_alias [NREG];
  logic [ROB_W-1:0] m_slot  [N_CKPT][NREG];
  bit               m_valid [N_CKPT];
  int               m_order [$];

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r] = '0;
      m_alias[r] = '0;
    end
    for (int i = 0; i < N_CKPT; i++) m_valid[i] = 1'b0;
    m_order.delete();
  endtask

  function automatic int m_free_id();
    for (int i = 0; i < N_CKPT; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int f;
    logic [XLEN-1:0] v;
    logic [ROB_W-1:0] q;
    int r;
    f = m_free_id();
    check("ckpt_full", 64'(rf_if.ckpt_full), 64'(f < 0));
    if (f >= 0) check("ckpt_free_id", 64'(rf_if.ckpt_free_id), 64'(f));
    for (int p = 0; p < RD_PORTS; p++) begin
      r = int'(rf_if.rd_reg[p]);
      v = m_reg[r];
      q = m_alias[r];
      for (int c = 0; c < CM_PORTS; c++)
        if (rf_if.cm_valid[c] && int'(rf_if.cm_reg[c]) == r && rf_if.cm_alias[c] == m_alias[r]) begin
          v = rf_if.cm_data[c];
          q = '0;
        end
      if (r == 0) begin
        v = '0;
        q = '0;
      end
      check($sformatf("rd_val%0d x%0d", p, r), 64'(rf_if.rd_val[p]), 64'(v));
      check($sformatf("rd_q%0d x%0d", p, r), 64'(rf_if.rd_q[p]), 64'(q));
    end
  endtask

  task automatic model_step();
    logic [ROB_W-1:0] cl [NREG];
    int f, r, k, rid;
    if (rst) begin
      model_reset();
      return;
    end
    if (!rf_if.rdy) return;
    f = m_free_id();
    for (int i = 0; i < NREG; i++) cl[i] = m_alias[i];
    for (int c = 0; c < CM_PORTS; c++) begin
      r = int'(rf_if.cm_reg[c]);
      if (rf_if.cm_valid[c] && r != 0) begin
        m_reg[r] = rf_if.cm_data[c];
        if (m_alias[r] == rf_if.cm_alias[c]) cl[r] = '0;
        for (int i = 0; i < N_CKPT; i++)
          if (m_valid[i] && m_slot[i][r] == rf_if.cm_alias[c]) m_slot[i][r] = '0;
      end
    end
    if (rf_if.flush) begin
      for (int i = 0; i < NREG; i++) m_alias[i] = '0;
      for (int i = 0; i < N_CKPT; i++) m_valid[i] = 1'b0;
      m_order.delete();
    end else if (rf_if.restore) begin
      rid = int'(rf_if.restore_id);
      for (int i = 0; i < NREG; i++) m_alias[i] = m_slot[rid][i];
      k = m_order.size();
      for (int i = 0; i < m_order.size(); i++) if (m_order[i] == rid) k = i;
      while (m_order.size() > k) begin
        m_valid[m_order[m_order.size()-1]] = 1'b0;
        void'(m_order.pop_back());
      end
    end else begin
      if (rf_if.ckpt_release && m_valid[int'(rf_if.ckpt_rel_id)]) begin
        m_valid[int'(rf_if.ckpt_rel_id)] = 1'b0;
        for (int i = 0; i < m_order.size(); i++)
          if (m_order[i] == int'(rf_if.ckpt_rel_id)) begin
            m_order.delete(i);
            break;
          end
      end
      if (rf_if.ckpt_alloc && f >= 0) begin
        for (int i = 0; i < NREG; i++) m_slot[f][i] = cl[i];
        m_valid[f] = 1'b1;
        m_order.push_back(f);
      end
      for (int i = 0; i < NREG; i++) m_alias[i] = cl[i];
      if (rf_if.ren_valid && rf_if.ren_reg != '0) m_alias[int'(rf_if.ren_reg)] = rf_if.ren_alias;
    end
  endtask

  // Drivers
  task automatic idle();
    rst = 1'b0;
    rf_if.rdy = 1'b1;
    rf_if.rd_reg = '0;
    rf_if.ren_valid = 1'b0;
    rf_if.ren_reg = '0;
    rf_if.ren_alias = '0;
    rf_if.cm_valid = '0;
    rf_if.cm_reg = '0;
    rf_if.cm_alias = '0;
    rf_if.cm_data = '0;
    rf_if.ckpt_alloc = 1'b0;
    rf_if.ckpt_release = 1'b0;
    rf_if.ckpt_rel_id = '0;
    rf_if.restore = 1'b0;
    rf_if.restore_id = '0;
    rf_if.flush = 1'b0;
  endtask

  task automatic step();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic commit(input int port, input int r, input int a, input logic [XLEN-1:0] d);
    rf_if.cm_valid[port] = 1'b1;
    rf_if.cm_reg[port]   = 5'(r);
    rf_if.cm_alias[port] = 4'(a);
    rf_if.cm_data[port]  = d;
  endtask

  task automatic rename(input int r, input int a);
    rf_if.ren_valid = 1'b1;
    rf_if.ren_reg   = 5'(r);
    rf_if.ren_alias = 4'(a);
  endtask

  task automatic drive_random();
    int r;
    idle();
    rst = ($urandom_range(0, 299) == 0);
    rf_if.rdy = ($urandom_range(0, 9) != 0);
    rf_if.flush = ($urandom_range(0, 59) == 0);
    if (m_order.size() > 0 && $urandom_range(0, 14) == 0) begin
      rf_if.restore = 1'b1;
      rf_if.restore_id = 2'(m_order[$urandom_range(0, m_order.size() - 1)]);
    end
    if ($urandom_range(0, 1) == 1) rename($urandom_range(0, 7), $urandom_range(1, 15));
    for (int c = 0; c < CM_PORTS; c++)
      if ($urandom_range(0, 9) < 4) begin
        r = (c == 1 && $urandom_range(0, 2) == 0) ? int'(rf_if.cm_reg[0]) : $urandom_range(0, 7);
        commit(c, r, ($urandom_range(0, 9) < 7) ? int'(m_alias[r]) : $urandom_range(1, 15), $urandom);
      end
    rf_if.ckpt_alloc = ($urandom_range(0, 3) == 0);
    rf_if.ckpt_release = ($urandom_range(0, 4) == 0);
    rf_if.ckpt_rel_id = 2'($urandom_range(0, 3));
    for (int p = 0; p < RD_PORTS; p++) rf_if.rd_reg[p] = 5'($urandom_range(0, 7));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    idle();
    for (int p = 0; p < RD_PORTS; p++) rf_if.rd_reg[p] = 5'(p + 1);
    #1;
    check("reset_full", 64'(rf_if.ckpt_full), 64'd0);
    check("reset_free_id", 64'(rf_if.ckpt_free_id), 64'd0);
    check("reset_rd_q1", 64'(rf_if.rd_q[1]), 64'd0);
    step();

    // Rename then same-cycle commit bypass, then retired value
    idle(); rename(5, 3); step();
    idle(); commit(0, 5, 3, 32'hDEAD); rf_if.rd_reg[0] = 5'd5; #1;
    check("bypass_val", 64'(rf_if.rd_val[0]), 64'hDEAD);
    check("bypass_q", 64'(rf_if.rd_q[0]), 64'd0);
    step();
    idle(); rf_if.rd_reg[0] = 5'd5; #1;
    check("retired_val", 64'(rf_if.rd_val[0]), 64'hDEAD);
    check("retired_q", 64'(rf_if.rd_q[0]), 64'd0);
    step();

    // Stale commit writes the value but keeps the younger alias
    idle(); rename(7, 2); step();
    idle(); rename(7, 6); step();
    idle(); commit(0, 7, 2, 32'h11); step();
    idle(); rf_if.rd_reg[1] = 5'd7; #1;
    check("stale_val", 64'(rf_if.rd_val[1]), 64'h11);
    check("stale_q", 64'(rf_if.rd_q[1]), 64'd6);
    step();

    // Checkpoint, rename, commit clears the snapshot, restore
    idle(); rename(3, 1); step();
    idle(); rf_if.ckpt_alloc = 1'b1; step();
    idle(); rename(3, 4); step();
    idle(); commit(0, 3, 1, 32'h5); step();
    idle(); rf_if.restore = 1'b1; rf_if.restore_id = 2'd0; step();
    idle(); rf_if.rd_reg[2] = 5'd3; #1;
    check("restore_q", 64'(rf_if.rd_q[2]), 64'd0);
    check("restore_val", 64'(rf_if.rd_val[2]), 64'h5);
    step();

    // Fill all slots, overflow, restore slot 1 frees 1..3
    idle(); rf_if.ckpt_alloc = 1'b1;
    repeat (N_CKPT) step();
    #1;
    check("full_after_4", 64'(rf_if.ckpt_full), 64'd1);
    step();
    idle(); rf_if.restore = 1'b1; rf_if.restore_id = 2'd1; step();
    idle(); #1;
    check("after_restore_full", 64'(rf_if.ckpt_full), 64'd0);
    check("after_restore_free", 64'(rf_if.ckpt_free_id), 64'd1);
    step();

    // Dual commit to one register; rename of x0 ignored
    idle(); commit(0, 9, 0, 32'hA); commit(1, 9, 0, 32'hB); step();
    idle(); rf_if.rd_reg[0] = 5'd9; #1;
    check("dual_commit", 64'(rf_if.rd_val[0]), 64'hB);
    step();
    idle(); rename(0, 5); step();
    idle(); #1;
    check("x0_q", 64'(rf_if.rd_q[0]), 64'd0);
    step();

    // rdy low holds everything
    idle(); rename(9, 7); step();
    idle(); rf_if.rdy = 1'b0; rename(9, 3); commit(0, 9, 7, 32'h77); step();
    idle(); rf_if.rd_reg[0] = 5'd9; #1;
    check("hold_q", 64'(rf_if.rd_q[0]), 64'd7);
    check("hold_val", 64'(rf_if.rd_val[0]), 64'hB);
    step();

    for (int n = 0; n < 3000; n++) begin
      drive_random();
      step();
    end

    // Reset mid-stream
    idle(); rename(5, 9); commit(0, 3, 1, 32'h1234); rst = 1'b1; step();
    idle(); rf_if.rd_reg[0] = 5'd5; rf_if.rd_reg[1] = 5'd7; rf_if.rd_reg[2] = 5'd9; rf_if.rd_reg[3] = 5'd3; #1;
    check("rst_free_id", 64'(rf_if.ckpt_free_id), 64'd0);
    check("rst_rd_val3", 64'(rf_if.rd_val[3]), 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
